// File: rtl/approx_mult_pkg.sv
// Shared definitions for the approximate-multiplier scheduler: state encoding,
// default truncation width and the leading-one helper.
package approx_mult_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int NUM_DEFAULT = 6;

  // Index of the most significant set bit; 0 for a zero input.
  function automatic logic [3:0] lead_one16(input logic [15:0] x);
    logic [3:0] k;
    k = '0;
    for (int i = 0; i < 16; i++) begin
      if (x[i]) k = 4'(i);
    end
    return k;
  endfunction

endpackage

// File: rtl/approx_mult_sched_core.sv
// Combinational 16x16 multiplier: exact product, or the scheme-1 approximation
// that keeps the NUM leading bits of each operand and shifts the product back.
module approx_mul_core
  import approx_mult_pkg::*;
#(
  parameter int NUM = NUM_DEFAULT
) (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        exact,
  output logic [31:0] y
);

  localparam logic [4:0] NUMW = 5'(NUM);

  logic [15:0] x [2];
  logic [15:0] m [2];
  logic [4:0]  s [2];
  logic [3:0]  k [2];
  logic [5:0]  shamt;

  assign x[0] = a;
  assign x[1] = b;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      k[i] = lead_one16(x[i]);
      if ({1'b0, k[i]} >= NUMW) begin
        s[i] = {1'b0, k[i]} - NUMW + 5'd1;
        m[i] = x[i] >> s[i];
      end else begin
        s[i] = '0;
        m[i] = x[i];
      end
    end
    shamt = 6'(s[0]) + 6'(s[1]);
    if (exact) y = 32'(a) * 32'(b);
    else       y = (32'(m[0]) * 32'(m[1])) << shamt;
  end

endmodule

// File: rtl/approx_mult_sched.sv
// Round-robin scheduler in front of one shared approximate multiplier; returns
// each product tagged with the requester index over a valid/ready port.
//
// state | meaning
// IDLE  | waiting for a request; grants the next one round-robin
// CALC  | operands registered, product being captured into y
// DONE  | result presented on y/y_id until the consumer takes it
module approx_mult_sched
  import approx_mult_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int NUM  = NUM_DEFAULT,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  input  logic                 exact_en,
  output logic                 y_valid,
  input  logic                 y_ready,
  output logic [31:0]          y,
  output logic [IDW-1:0]       y_id,
  output logic                 busy
);

  logic [1:0]      state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [15:0]     a_q, a_d, b_q, b_d;
  logic            exact_q, exact_d;
  logic [31:0]     y_q, y_d;
  logic [31:0]     core_y;
  logic            found;
  logic [IDW-1:0]  gnt_idx;
  logic [NREQ-1:0] gnt;

  approx_mul_core #(.NUM(NUM)) u_core (
    .a     (a_q),
    .b     (b_q),
    .exact (exact_q),
    .y     (core_y)
  );

  // First pending requester after the last one served.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int off = 1; off <= NREQ; off++) begin
      if (!found && req_valid[(int'(ptr_q) + off) % NREQ]) begin
        found   = 1'b1;
        gnt_idx = IDW'((int'(ptr_q) + off) % NREQ);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    exact_d = exact_q;
    y_d     = y_q;
    gnt     = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt     = NREQ'(1) << gnt_idx;
          a_d     = req_a[{gnt_idx, 4'b0} +: 16];
          b_d     = req_b[{gnt_idx, 4'b0} +: 16];
          exact_d = exact_en;
          id_d    = gnt_idx;
          ptr_d   = gnt_idx;
          state_d = CALC;
        end
      end
      CALC: begin
        y_d     = core_y;
        state_d = DONE;
      end
      DONE: begin
        if (y_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= IDW'(NREQ - 1);
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      exact_q <= 1'b0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      exact_q <= exact_d;
      y_q     <= y_d;
    end
  end

  // Reset wins over both handshakes in the same cycle.
  assign req_ready = rst ? '0 : gnt;
  assign y_valid   = !rst && (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign y         = y_q;
  assign y_id      = id_q;

endmodule

// File: tb/tb_approx_mult_sched.sv
// Self-checking bench for approx_mult_sched: directed vector table, multi-cycle
// corner sequences and a randomized run against a transaction-level model.
module tb_approx_mult_sched;

  localparam int NREQ = 4;
  localparam int NUM  = 6;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [16*NREQ-1:0]  req_a = '0;
  logic [16*NREQ-1:0]  req_b = '0;
  logic                exact_en = 1'b0;
  logic                y_valid;
  logic                y_ready = 1'b1;
  logic [31:0]         y;
  logic [IDW-1:0]      y_id;
  logic                busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  approx_mult_sched #(.NREQ(NREQ), .NUM(NUM), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .exact_en  (exact_en),
    .y_valid   (y_valid),
    .y_ready   (y_ready),
    .y         (y),
    .y_id      (y_id),
    .busy      (busy)
  );

  typedef struct {
    int          id;
    logic [15:0] a;
    logic [15:0] b;
    bit          exact;
    logic [31:0] exp_y;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Keep the NUM leading bits by halving until the value fits, then scale back.
  function automatic logic [31:0] ref_mul(input int unsigned a, input int unsigned b, input bit exact);
    longint unsigned p;
    int unsigned ma, mb;
    int sh;
    if (exact) begin
      p = a;
      p = p * b;
    end else begin
      ma = a; mb = b; sh = 0;
      while (ma >= (1 << NUM)) begin ma = ma / 2; sh++; end
      while (mb >= (1 << NUM)) begin mb = mb / 2; sh++; end
      p = ma;
      p = (p * mb) << sh;
    end
    return p[31:0];
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] pend, input int last);
    for (int off = 1; off <= NREQ; off++) begin
      if (pend[(last + off) % NREQ]) return (last + off) % NREQ;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; y_ready = 1'b1; exact_en = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_y_valid", 32'(y_valid), 32'd0);
    chk("rst_y", y, 32'd0);
    chk("rst_y_id", 32'(y_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
  endtask

  task automatic do_txn(input vec_t v);
    req_valid = '0;
    req_valid[v.id] = 1'b1;
    req_a[16*v.id +: 16] = v.a;
    req_b[16*v.id +: 16] = v.b;
    exact_en = v.exact;
    y_ready = 1'b1;
    #1;
    chk("vec_grant", 32'(req_ready), 32'(1 << v.id));
    tick();
    req_valid = '0;
    exact_en = ~v.exact;
    #1;
    chk("vec_calc_valid", 32'(y_valid), 32'd0);
    chk("vec_calc_busy", 32'(busy), 32'd1);
    tick();
    #1;
    chk("vec_done_valid", 32'(y_valid), 32'd1);
    chk("vec_y", y, v.exp_y);
    chk("vec_y_id", 32'(y_id), 32'(v.id));
    tick();
    exact_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0]     opa [NREQ];
    logic [15:0]     opb [NREQ];
    int              gids [$];
    int              gcyc [$];
    logic [31:0]     rexp [$];
    int              rid  [$];
    logic [NREQ-1:0] pend;
    int              mptr, mid, age, e;
    bit              infl, was_infl;
    logic [31:0]     my;
    logic [31:0]     held_y;

    vecs[0] = '{0, 16'd5,      16'd7,      1'b0, 32'd35};
    vecs[1] = '{2, 16'hFFAA,   16'h08FA,   1'b0, 32'h089D0000};
    vecs[2] = '{2, 16'hFFAA,   16'h08FA,   1'b1, 32'd150404100};
    vecs[3] = '{1, 16'hFFFF,   16'hFFFF,   1'b0, 32'hF8100000};
    vecs[4] = '{3, 16'hFFFF,   16'hFFFF,   1'b1, 32'hFFFE0001};
    vecs[5] = '{1, 16'h0000,   16'h1234,   1'b0, 32'd0};
    vecs[6] = '{0, 16'h0041,   16'h0003,   1'b0, 32'd192};
    vecs[7] = '{3, 16'h0041,   16'h0003,   1'b1, 32'd195};

    do_reset();
    for (int i = 0; i < 8; i++) do_txn(vecs[i]);

    // All requesters held valid: strict rotation, one grant every 3 cycles.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      opa[i] = 16'($urandom);
      opb[i] = 16'($urandom);
      req_a[16*i +: 16] = opa[i];
      req_b[16*i +: 16] = opb[i];
    end
    req_valid = '1;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (y_valid && rexp.size() > 0) begin
        chk("rr_y", y, rexp.pop_front());
        chk("rr_y_id", 32'(y_id), 32'(rid.pop_front()));
      end
      if (req_ready != '0) begin
        gids.push_back($clog2(req_ready));
        gcyc.push_back(c);
        rexp.push_back(ref_mul(opa[$clog2(req_ready)], opb[$clog2(req_ready)], 1'b0));
        rid.push_back($clog2(req_ready));
      end
      tick();
    end
    req_valid = '0;
    chk("rr_grant_count_ge5", 32'(gids.size() >= 5), 32'd1);
    if (gids.size() >= 5) begin
      for (int k = 0; k < 5; k++) begin
        chk("rr_id_seq", 32'(gids[k]), 32'(k % NREQ));
        if (k > 0) chk("rr_interval", 32'(gcyc[k] - gcyc[k-1]), 32'd3);
      end
    end

    // Consumer stalls for 5 cycles in DONE while another requester waits.
    do_reset();
    req_valid = 4'b0100;
    req_a[32 +: 16] = 16'h1234;
    req_b[32 +: 16] = 16'h00FF;
    y_ready = 1'b0;
    #1;
    chk("stall_grant", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0010;
    req_a[16 +: 16] = 16'd9;
    req_b[16 +: 16] = 16'd9;
    tick();
    held_y = ref_mul(32'h1234, 32'h00FF, 1'b0);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("stall_valid", 32'(y_valid), 32'd1);
      chk("stall_y", y, held_y);
      chk("stall_y_id", 32'(y_id), 32'd2);
      chk("stall_no_ready", 32'(req_ready), 32'd0);
      tick();
    end
    y_ready = 1'b1;
    #1;
    chk("release_valid", 32'(y_valid), 32'd1);
    tick();
    #1;
    chk("release_idle", 32'(busy), 32'd0);
    chk("release_next_grant", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    tick(); tick();

    // Reset during CALC discards the transaction and restarts the pointer.
    do_reset();
    req_valid = 4'b0100;
    #1;
    chk("rstcalc_grant", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("rstcalc_no_valid", 32'(y_valid), 32'd0);
      chk("rstcalc_busy", 32'(busy), 32'd0);
      tick();
    end
    req_valid = '1;
    #1;
    chk("rstcalc_first_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    tick(); tick(); tick();

    // Randomized traffic against the transaction-level model.
    do_reset();
    pend = '0; mptr = NREQ - 1; infl = 1'b0; age = 0; mid = 0; my = '0;
    for (int i = 0; i < NREQ; i++) begin opa[i] = '0; opb[i] = '0; end
    for (int c = 0; c < 400; c++) begin
      req_valid = pend;
      for (int i = 0; i < NREQ; i++) begin
        req_a[16*i +: 16] = opa[i];
        req_b[16*i +: 16] = opb[i];
      end
      exact_en = 1'($urandom % 2);
      y_ready  = (($urandom % 4) != 0);
      #1;
      was_infl = infl;
      if (infl && age >= 2) begin
        chk("rand_valid", 32'(y_valid), 32'd1);
        chk("rand_y", y, my);
        chk("rand_y_id", 32'(y_id), 32'(mid));
        if (y_ready) infl = 1'b0;
      end else begin
        chk("rand_no_valid", 32'(y_valid), 32'd0);
      end
      if (!was_infl && pend != '0) begin
        e = rr_pick(pend, mptr);
        chk("rand_grant", 32'(req_ready), 32'(1 << e));
        my   = ref_mul(opa[e], opb[e], exact_en);
        mid  = e;
        mptr = e;
        infl = 1'b1;
        age  = 0;
        pend[e] = 1'b0;
      end else begin
        chk("rand_no_grant", 32'(req_ready), 32'd0);
      end
      tick();
      age++;
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && ($urandom % 3) == 0) begin
          pend[i] = 1'b1;
          case ($urandom % 6)
            0:       opa[i] = 16'hFFFF;
            1:       opa[i] = 16'h0000;
            default: opa[i] = 16'($urandom);
          endcase
          opb[i] = (($urandom % 8) == 0) ? 16'($urandom % 64) : 16'($urandom);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
